// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//
// Upstream controller for a 16-to-1 multiplexer. On a start request it
// enables the mux and sweeps the select through 0..15. It holds each select
// value for SETTLE_CYCLES cycles and then spends one SAMPLE cycle
// registering the returned mux output into the matching bit of a shadow
// word. After the last select value the complete word is transferred to
// capture, and done pulses for one cycle.
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst      in   1   asynchronous active-high reset
//   start    in   1   scan request, honoured only while idle
//   abort    in   1   synchronous scan cancel (no done, capture unchanged)
//   y_in     in   1   mux output Y, sampled in the SAMPLE state
//   sel      out  4   mux select S
//   en_n     out  1   mux active-low enable E_N
//   busy     out  1   high while a scan is in progress
//   done     out  1   one-cycle pulse when capture is updated
//   capture  out  16  last completed scan; bit i = Y seen with sel=i
//
// Every output comes straight from a flop, so no input reaches an output
// through combinational logic.
module mux_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        y_in,
  output logic [3:0]  sel,
  output logic        en_n,
  output logic        busy,
  output logic        done,
  output logic [15:0] capture
);

  // The settle counter is 8 bits wide, and a zero settle time has no
  // meaning, so reject any value outside 1..255 during elaboration.
  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("mux_scan_sequencer: SETTLE_CYCLES must be in 1..255");
    end
  endgenerate

  localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  // Only bits 0..14 are stored here. Bit 15 goes straight from y_in into
  // capture on the closing edge.
  logic [14:0] shadow_q;
  logic [3:0]  sel_q;
  logic        en_n_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] capture_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      shadow_q  <= 15'd0;
      sel_q     <= 4'd0;
      en_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      capture_q <= 16'h0000;
    end else begin
      // done is a single-cycle pulse. It is cleared by default on every edge.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // When start and abort arrive together, abort wins, so the
          // start request is dropped.
          if (start && !abort) begin
            state_q  <= SETTLE;
            sel_q    <= 4'd0;
            en_n_q   <= 1'b0;
            busy_q   <= 1'b1;
            cnt_q    <= 8'd0;
            shadow_q <= 15'd0;
          end
        end

        SETTLE: begin
          if (abort) begin
            state_q <= IDLE;
            sel_q   <= 4'd0;
            en_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= 8'd0;
          end else if (cnt_q == LAST_CNT) begin
            state_q <= SAMPLE;
            cnt_q   <= 8'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        SAMPLE: begin
          // abort takes priority even over the final completing sample.
          if (abort) begin
            state_q <= IDLE;
            sel_q   <= 4'd0;
            en_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= 8'd0;
          end else if (sel_q != 4'd15) begin
            shadow_q[sel_q] <= y_in;
            sel_q           <= sel_q + 4'd1;
            state_q         <= SETTLE;
          end else begin
            capture_q <= {y_in, shadow_q};
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            en_n_q    <= 1'b1;
            sel_q     <= 4'd0;
            state_q   <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          sel_q   <= 4'd0;
          en_n_q  <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

  assign sel     = sel_q;
  assign en_n    = en_n_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign capture = capture_q;

endmodule
